demux4_stream: RTL
==================

// Module: demux4_stream
//
// PURPOSE
//   1-to-4 registered demultiplexer with valid/ready handshake: routes one input
//   word to one of four output channels, selected per word by a 2-bit select.
//   Each channel has a one-entry holding register, so a stalled consumer blocks
//   only its own channel. Used on the datapath wherever one producer feeds
//   several consumers (writeback fan-out, per-unit issue), opposite to mux4.
//
// PARAMETERS
//   n   32   data width in bits of D and every Y output
//
// PORTS
//   clk        in   1     rising-edge clock
//   rst_n      in   1     asynchronous reset, active low
//   D          in   n     input data word
//   S          in   2     destination channel for D (0..3)
//   in_valid   in   1     D/S valid this cycle
//   in_ready   out  1     demux accepts D this cycle
//   Y0..Y3     out  n     channel data, from holding registers
//   out_valid  out  4     bit k: Yk holds a valid word
//   out_ready  in   4     bit k: consumer k takes Yk this cycle
//   count      out  32    (only with DEMUX4_STATS_EN) 4x8-bit counters, [8k+7:8k] = channel k
//
// BEHAVIOUR
//   - Reset (rst_n=0, async): out_valid=4'b0000, Y0..Y3=0, count=0; held words discarded.
//   - Transfer in: in_valid & in_ready at rising edge. Transfer out k: out_valid[k] & out_ready[k].
//   - Per channel k, 2-state FSM:
//       EMPTY: load (in transfer with S==k) -> FULL, Yk<=D; else stay EMPTY.
//       FULL : out xfer & no load -> EMPTY; out xfer & load -> FULL, Yk<=D;
//              no out xfer -> stay FULL, Yk held stable.
//   - out_valid[k] = (state_k == FULL), registered output.
//   - in_ready = ~out_valid[S] | out_ready[S]; combinational from S, out_valid and
//     out_ready (same-cycle drain+refill at full throughput). No in_valid->in_ready path.
//   - Latency: word accepted in cycle t appears on Y[S] with out_valid[S]=1 in t+1.
//   - Throughput: one word per cycle while the selected consumer keeps up.
//   - Only channel S can load in a cycle; other channels drain independently in the same cycle.
//   - Ordering: in-order per channel; no ordering guarantee across channels.
//   - Y and out_valid stable while out_valid[k]=1 & out_ready[k]=0.
//   - in_valid=0: S and D ignored; in_ready still reflects S.
//   - rst_n deasserted synchronously to clk by the system; first transfer 1 cycle after release.
//
// CONFIGURATION
//   DEMUX4_STATS_EN defined: port count present; channel k counter +1 on each
//     load into channel k; saturates at 8'hFF (no wrap); cleared only by reset.
//   Not defined: port count and counter logic absent; all other behaviour identical.
//
// TESTING
//   1. Reset: rst_n=0 mid-stream, channel 2 FULL -> out_valid=0000, Y2=0 immediately, no clk needed.
//   2. Routing: in D=32'hA5A5_0001,S=1,valid 1 cycle, out_ready=1111 -> next cycle
//      Y1=32'hA5A5_0001, out_valid=0010; following cycle out_valid=0000.
//   3. Stall: out_ready[3]=0, send two words S=3 -> first lands, in_ready=0 while S=3;
//      S=0 word accepted, appears on Y0 next cycle; raise out_ready[3] -> second S=3 accepted.
//   4. Full throughput: out_ready=1111, words 1..8 S=2 back-to-back -> in_ready=1 every cycle,
//      Y2 = 1..8 on consecutive cycles, out_valid[2]=1 for 8 cycles.
//   5. Simultaneous: channel 0 FULL, out_ready[0]=1 and new word S=0 same cycle -> in_ready=1,
//      old word consumed, new word on Y0 next cycle, out_valid[0] stays 1.
//   6. Stats (DEMUX4_STATS_EN): 300 loads to channel 1 -> count[15:8]=8'hFF, other fields 0.

Source files
------------

// File: rtl/demux4_stream.sv
// demux4_stream: 1-to-4 registered demultiplexer with valid/ready handshake.
// One-entry holding register per channel; DEMUX4_STATS_EN adds per-channel load counters.
//
// Channel FSM (one per output k):
//   state | meaning
//   EMPTY | no word held, out_valid[k]=0
//   FULL  | Yk holds a word, out_valid[k]=1
module demux4_stream #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [n-1:0] D,
  input  logic [1:0]   S,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [n-1:0] Y0,
  output logic [n-1:0] Y1,
  output logic [n-1:0] Y2,
  output logic [n-1:0] Y3,
  output logic [3:0]   out_valid,
  input  logic [3:0]   out_ready
`ifdef DEMUX4_STATS_EN
  ,
  output logic [31:0]  count
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_e;

  chan_state_e  state_q [4];
  chan_state_e  state_d [4];
  logic [n-1:0] data_q  [4];
  logic [3:0]   load;
  logic [3:0]   drain;
  logic         in_xfer;

  // The selected channel can take a word if it is empty or is draining this cycle.
  assign in_ready = ~out_valid[S] | out_ready[S];
  assign in_xfer  = in_valid & in_ready;
  assign load     = in_xfer ? (4'b0001 << S) : 4'b0000;
  assign drain    = out_valid & out_ready;

  always_comb begin
    out_valid = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      out_valid[k] = (state_q[k] == FULL);
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      state_d[k] = state_q[k];
      case (state_q[k])
        EMPTY: if (load[k]) state_d[k] = FULL;
        FULL:  if (drain[k] && !load[k]) state_d[k] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= EMPTY;
        data_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= state_d[k];
        if (load[k]) data_q[k] <= D;
      end
    end
  end

  assign Y0 = data_q[0];
  assign Y1 = data_q[1];
  assign Y2 = data_q[2];
  assign Y3 = data_q[3];

`ifdef DEMUX4_STATS_EN
  logic [7:0] cnt_q [4];

  // Counters saturate rather than wrap so a long run never reads as a short one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) cnt_q[k] <= 8'h00;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (load[k] && (cnt_q[k] != 8'hFF)) cnt_q[k] <= cnt_q[k] + 8'h01;
      end
    end
  end

  assign count = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule
